// File: rtl/divider_if.sv
// Request/response bundle between the execute stage and the divide/remainder unit.
// The execute stage drives the master modport; divider_unit takes the slave modport.
interface divider_if #(
  parameter int WIDTH = 32
) ();
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             flush;
  logic [WIDTH-1:0] Result;
  logic             busy;
  logic             done;
  logic             DivByZero;

  modport master (
    output start, op, A, B, flush,
    input  Result, busy, done, DivByZero
  );

  modport slave (
    input  start, op, A, B, flush,
    output Result, busy, done, DivByZero
  );
endinterface

// File: rtl/divider_unit.sv
// RV32M DIV/DIVU/REM/REMU unit using a radix-2 restoring loop, one quotient bit per cycle.
// Optional macro DIV_EARLY_OUT_EN: divide-by-zero and signed overflow complete one cycle after start.
module divider_unit #(
  parameter int WIDTH = 32
) (
  input  logic      clk,
  input  logic      rst,
  divider_if.slave  bus
);
  localparam int               CNT_W    = $clog2(WIDTH + 1);
  localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] MIN_NEG  = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t           state_q;
  logic [1:0]       op_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] bmag_q;
  logic [WIDTH-1:0] dvd_q;
  logic [WIDTH:0]   rem_q;
  logic             qneg_q;
  logic             rneg_q;
  logic             bzero_q;
  logic             ovf_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] result_q;
  logic             busy_q;
  logic             done_q;
  logic             dbz_q;

  logic             is_signed_d;
  logic             a_neg_d;
  logic             b_neg_d;
  logic             b_zero_d;
  logic             ovf_d;
  logic             early_d;
  logic [WIDTH-1:0] a_mag_d;
  logic [WIDTH-1:0] b_mag_d;
  logic [WIDTH:0]   rem_shift_d;
  logic [WIDTH:0]   trial_d;
  logic [WIDTH-1:0] sel_d;
  logic [WIDTH-1:0] fix_res_d;

  function automatic logic [WIDTH-1:0] negate(input logic [WIDTH-1:0] v);
    return (~v) + {{(WIDTH-1){1'b0}}, 1'b1};
  endfunction

  // Architecturally fixed results: divide-by-zero first, otherwise signed overflow.
  function automatic logic [WIDTH-1:0] special_result(input logic [1:0] op,
                                                      input logic [WIDTH-1:0] a,
                                                      input logic bzero);
    logic [WIDTH-1:0] r;
    if (bzero) begin
      r = op[1] ? a : ALL_ONES;
    end else begin
      r = op[1] ? {WIDTH{1'b0}} : MIN_NEG;
    end
    return r;
  endfunction

  // Operand decode at request time: magnitudes, sign flags and special-case detection.
  always_comb begin
    is_signed_d = ~bus.op[0];
    a_neg_d     = is_signed_d & bus.A[WIDTH-1];
    b_neg_d     = is_signed_d & bus.B[WIDTH-1];
    a_mag_d     = a_neg_d ? negate(bus.A) : bus.A;
    b_mag_d     = b_neg_d ? negate(bus.B) : bus.B;
    b_zero_d    = (bus.B == {WIDTH{1'b0}});
    ovf_d       = is_signed_d & (bus.A == MIN_NEG) & (bus.B == ALL_ONES);
`ifdef DIV_EARLY_OUT_EN
    early_d     = b_zero_d | ovf_d;
`else
    early_d     = 1'b0;
`endif
  end

  // One restoring step plus the sign/special fix-up applied in FIX.
  always_comb begin
    rem_shift_d = {rem_q[WIDTH-1:0], dvd_q[WIDTH-1]};
    trial_d     = rem_shift_d - {1'b0, bmag_q};
    sel_d       = op_q[1] ? rem_q[WIDTH-1:0] : dvd_q;
    if (bzero_q | ovf_q) begin
      fix_res_d = special_result(op_q, a_q, bzero_q);
    end else begin
      fix_res_d = (op_q[1] ? rneg_q : qneg_q) ? negate(sel_d) : sel_d;
    end
  end

  // Control FSM and datapath registers; rst beats flush beats start.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= IDLE;
      op_q     <= 2'b00;
      a_q      <= {WIDTH{1'b0}};
      bmag_q   <= {WIDTH{1'b0}};
      dvd_q    <= {WIDTH{1'b0}};
      rem_q    <= {(WIDTH+1){1'b0}};
      qneg_q   <= 1'b0;
      rneg_q   <= 1'b0;
      bzero_q  <= 1'b0;
      ovf_q    <= 1'b0;
      cnt_q    <= {CNT_W{1'b0}};
      result_q <= {WIDTH{1'b0}};
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      dbz_q    <= 1'b0;
    end else if (bus.flush) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            op_q    <= bus.op;
            a_q     <= bus.A;
            bmag_q  <= b_mag_d;
            dvd_q   <= a_mag_d;
            rem_q   <= {(WIDTH+1){1'b0}};
            qneg_q  <= a_neg_d ^ b_neg_d;
            rneg_q  <= a_neg_d;
            bzero_q <= b_zero_d;
            ovf_q   <= ovf_d;
            cnt_q   <= CNT_W'(WIDTH);
            if (early_d) begin
              state_q  <= DONE;
              result_q <= special_result(bus.op, bus.A, b_zero_d);
              dbz_q    <= b_zero_d;
              done_q   <= 1'b1;
              busy_q   <= 1'b0;
            end else begin
              state_q <= CALC;
              busy_q  <= 1'b1;
            end
          end else begin
            state_q <= IDLE;
          end
        end
        CALC: begin
          // A clear top bit means the trial subtraction did not borrow.
          if (!trial_d[WIDTH]) begin
            rem_q <= trial_d;
            dvd_q <= {dvd_q[WIDTH-2:0], 1'b1};
          end else begin
            rem_q <= rem_shift_d;
            dvd_q <= {dvd_q[WIDTH-2:0], 1'b0};
          end
          cnt_q <= cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            state_q <= FIX;
          end else begin
            state_q <= CALC;
          end
        end
        FIX: begin
          result_q <= fix_res_d;
          dbz_q    <= bzero_q;
          done_q   <= 1'b1;
          busy_q   <= 1'b0;
          state_q  <= DONE;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.Result    = result_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.DivByZero = dbz_q;
endmodule

// File: tb/tb_divider_unit.sv
// Directed bench for divider_unit: arithmetic results, latency, special cases, flush, reset, back-to-back.
module tb_divider_unit;
  localparam int FULL_LAT = 34;
`ifdef DIV_EARLY_OUT_EN
  localparam int EARLY_LAT = 1;
`else
  localparam int EARLY_LAT = 34;
`endif

  logic clk = 1'b0;
  logic rst;
  int   vectors = 0;
  int   miscompares = 0;
  logic [31:0] last_res = 32'h0;

  always #5 clk = ~clk;

  divider_if #(.WIDTH(32)) dif ();
  divider_unit #(.WIDTH(32)) dut (.clk(clk), .rst(rst), .bus(dif));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    vectors++;
    if (dif.Result !== 32'h0) begin miscompares++; $display("FAIL reset_result: got %h expected %h", dif.Result, 32'h0); end
    vectors++;
    if ({dif.busy, dif.done, dif.DivByZero} !== 3'b000) begin
      miscompares++; $display("FAIL reset_flags: got %b expected %b", {dif.busy, dif.done, dif.DivByZero}, 3'b000);
    end
  endtask

  // Issue one operation, then check latency, busy span, result, flag and the one-cycle done pulse.
  task automatic run_op(input string name, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_res,
                        input logic exp_dbz, input logic special);
    int lat, cyc, done_cyc, busy_cnt;
    lat = special ? EARLY_LAT : FULL_LAT;
    @(negedge clk);
    dif.op = op; dif.A = a; dif.B = b; dif.start = 1'b1;
    step();
    dif.start = 1'b0;
    cyc = 1; done_cyc = 0; busy_cnt = 0;
    while (done_cyc == 0 && cyc <= 60) begin
      if (dif.done === 1'b1) begin
        done_cyc = cyc;
      end else begin
        if (dif.busy === 1'b1) busy_cnt++;
        step();
        cyc++;
      end
    end
    vectors++;
    if (done_cyc != lat) begin miscompares++; $display("FAIL %s_latency: got %0d expected %0d", name, done_cyc, lat); end
    vectors++;
    if (busy_cnt != lat - 1) begin miscompares++; $display("FAIL %s_busy_cycles: got %0d expected %0d", name, busy_cnt, lat - 1); end
    vectors++;
    if (dif.busy !== 1'b0) begin miscompares++; $display("FAIL %s_busy_at_done: got %b expected 0", name, dif.busy); end
    vectors++;
    if (dif.Result !== exp_res) begin miscompares++; $display("FAIL %s_result: got %h expected %h", name, dif.Result, exp_res); end
    vectors++;
    if (dif.DivByZero !== exp_dbz) begin miscompares++; $display("FAIL %s_divbyzero: got %b expected %b", name, dif.DivByZero, exp_dbz); end
    step();
    vectors++;
    if (dif.done !== 1'b0) begin miscompares++; $display("FAIL %s_done_pulse: got %b expected 0", name, dif.done); end
    vectors++;
    if (dif.Result !== exp_res) begin miscompares++; $display("FAIL %s_result_hold: got %h expected %h", name, dif.Result, exp_res); end
    last_res = exp_res;
  endtask

  task automatic expect_no_done(input string name, input int cycles);
    int seen;
    seen = 0;
    for (int i = 0; i < cycles; i++) begin
      if (dif.done === 1'b1 || dif.busy === 1'b1) seen++;
      step();
    end
    vectors++;
    if (seen != 0) begin miscompares++; $display("FAIL %s_quiet: got %0d active cycles expected 0", name, seen); end
  endtask

  task automatic test_arith();
    run_op("div_100_7",   2'b00, 32'd100,      32'd7, 32'd14,       1'b0, 1'b0);
    run_op("rem_100_7",   2'b10, 32'd100,      32'd7, 32'd2,        1'b0, 1'b0);
    run_op("rem_m100_7",  2'b10, 32'hFFFFFF9C, 32'd7, 32'hFFFFFFFE, 1'b0, 1'b0);
    run_op("div_m100_7",  2'b00, 32'hFFFFFF9C, 32'd7, 32'hFFFFFFF2, 1'b0, 1'b0);
    run_op("divu_max_2",  2'b01, 32'hFFFFFFFF, 32'd2, 32'h7FFFFFFF, 1'b0, 1'b0);
    run_op("remu_max_2",  2'b11, 32'hFFFFFFFF, 32'd2, 32'h00000001, 1'b0, 1'b0);
    run_op("div_m1_2",    2'b00, 32'hFFFFFFFF, 32'd2, 32'h00000000, 1'b0, 1'b0);
    run_op("rem_m1_2",    2'b10, 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFF, 1'b0, 1'b0);
    run_op("div_100_m7",  2'b00, 32'd100, 32'hFFFFFFF9, 32'hFFFFFFF2, 1'b0, 1'b0);
  endtask

  task automatic test_special();
    run_op("div_by0",  2'b00, 32'h12345678, 32'h0, 32'hFFFFFFFF, 1'b1, 1'b1);
    run_op("divu_by0", 2'b01, 32'h12345678, 32'h0, 32'hFFFFFFFF, 1'b1, 1'b1);
    run_op("rem_by0",  2'b10, 32'h12345678, 32'h0, 32'h12345678, 1'b1, 1'b1);
    run_op("remu_by0", 2'b11, 32'h12345678, 32'h0, 32'h12345678, 1'b1, 1'b1);
    run_op("div_ovf",  2'b00, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b0, 1'b1);
    run_op("rem_ovf",  2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1'b0, 1'b1);
    run_op("divu_big", 2'b01, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1'b0, 1'b0);
  endtask

  task automatic test_flush();
    logic [31:0] prev;
    prev = last_res;
    @(negedge clk);
    dif.op = 2'b00; dif.A = 32'd1000; dif.B = 32'd3; dif.start = 1'b1;
    step();
    dif.start = 1'b0;
    repeat (9) step();
    dif.flush = 1'b1;
    step();
    dif.flush = 1'b0;
    vectors++;
    if ({dif.busy, dif.done} !== 2'b00) begin miscompares++; $display("FAIL flush_idle: got %b expected 00", {dif.busy, dif.done}); end
    vectors++;
    if (dif.Result !== prev) begin miscompares++; $display("FAIL flush_result: got %h expected %h", dif.Result, prev); end
    expect_no_done("flush", 40);
    @(negedge clk);
    dif.op = 2'b01; dif.A = 32'd50; dif.B = 32'd5; dif.start = 1'b1; dif.flush = 1'b1;
    step();
    dif.start = 1'b0; dif.flush = 1'b0;
    expect_no_done("flush_start", 40);
    vectors++;
    if (dif.Result !== prev) begin miscompares++; $display("FAIL flush_start_result: got %h expected %h", dif.Result, prev); end
    run_op("after_flush", 2'b01, 32'd50, 32'd5, 32'd10, 1'b0, 1'b0);
  endtask

  task automatic test_midop_reset();
    @(negedge clk);
    dif.op = 2'b01; dif.A = 32'hDEADBEEF; dif.B = 32'd9; dif.start = 1'b1;
    step();
    dif.start = 1'b0;
    repeat (19) step();
    rst = 1'b0;
    step();
    rst = 1'b1;
    test_reset();
    expect_no_done("reset", 40);
    run_op("after_reset", 2'b01, 32'd81, 32'd9, 32'd9, 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back();
    int cyc;
    @(negedge clk);
    dif.op = 2'b00; dif.A = 32'd100; dif.B = 32'd7; dif.start = 1'b1;
    step();
    dif.start = 1'b0;
    cyc = 1;
    while (dif.done !== 1'b1 && cyc <= 60) begin step(); cyc++; end
    vectors++;
    if (cyc != FULL_LAT) begin miscompares++; $display("FAIL b2b_first_latency: got %0d expected %0d", cyc, FULL_LAT); end
    vectors++;
    if (dif.Result !== 32'd14) begin miscompares++; $display("FAIL b2b_first_result: got %h expected %h", dif.Result, 32'd14); end
    dif.op = 2'b10; dif.start = 1'b1;
    step();
    dif.start = 1'b0;
    cyc = 1;
    while (dif.done !== 1'b1 && cyc <= 60) begin step(); cyc++; end
    vectors++;
    if (cyc != FULL_LAT) begin miscompares++; $display("FAIL b2b_second_latency: got %0d expected %0d", cyc, FULL_LAT); end
    vectors++;
    if (dif.Result !== 32'd2) begin miscompares++; $display("FAIL b2b_second_result: got %h expected %h", dif.Result, 32'd2); end
    step();
  endtask

  initial begin
    dif.start = 1'b0; dif.op = 2'b00; dif.A = 32'h0; dif.B = 32'h0; dif.flush = 1'b0;
    rst = 1'b0;
    repeat (3) step();
    test_reset();
    rst = 1'b1;
    step();
    test_arith();
    test_special();
    test_flush();
    test_midop_reset();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
